uart_rx_edge_bit_sampler: RTL and testbench
===========================================

# uart_rx_edge_bit_sampler

Oversampling timebase and bit sampler for the UART receiver. It counts receive-clock edges within each bit period and bits within each frame. It produces a majority-voted sample of RX_IN once per bit. It sits directly upstream of the RX control FSM, which consumes edge_count, bit_count and the sampled bit, and drives enable and data_sample_en back into this block.

## Interface
Parameters: none; all configuration is through ports.

Ports:
- clk  in  1  receive oversampling clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  counter enable, driven by the FSM's counter_enable; low clears both counters
- data_sample_en  in  1  allows sample capture and sample_valid
- RX_IN  in  1  serial line, already synchronous to clk
- PAR_EN  in  1  frame carries a parity bit
- Prescale  in  6  oversampling ratio; legal values are 8, 16 and 32
- edge_count  out  5  edge index within the current bit, 0..Prescale-1
- bit_count  out  4  bit index within the frame (start bit = 0)
- sampled_bit  out  1  registered voted value of the current bit
- sample_valid  out  1  one-cycle pulse when sampled_bit updates
- sample_glitch  out  1  the three samples disagreed; valid with sample_valid

## Operation
- Reset values:
  - edge_count = 0, bit_count = 0
  - sampled_bit = 1 (idle line)
  - sample_valid = 0, sample_glitch = 0
- enable low: at the next clk, edge_count and bit_count go to 0, sample_valid goes to 0, and sample registers hold. enable low overrides all other events.
- enable high: edge_count increments every clk.
- Bit boundary: when {1'b0, edge_count} == Prescale-1 (6-bit compare), edge_count wraps to 0 and bit_count advances.
- Frame length is F = 10 + PAR_EN bits. When bit_count == F-1 at a bit boundary, bit_count wraps to 0 rather than incrementing.
- Because of this wrap, back-to-back frames run with enable held high and need no clear.
- Sample points, with H = Prescale>>1, captured only while enable and data_sample_en are both high:
  - s0 is captured when edge_count == H-2
  - s1 is captured when edge_count == H-1
  - s2 is captured when edge_count == H
- Decision: on the clk where edge_count == H+1 and data_sample_en is high:
  - sampled_bit <= majority(s0, s1, s2)
  - sample_glitch <= (s0 != s1) | (s1 != s2)
  - sample_valid <= 1
- sample_valid is high for exactly one cycle per bit, and is 0 whenever data_sample_en is low.
- data_sample_en deasserted mid-bit: captures already taken are kept. If it is low at H+1, no decision is made that bit.
- Prescale may change only while enable is low. Illegal Prescale values give undefined sample placement but counters still wrap at Prescale-1. Illegal values are not verified.
- Async reset asserted mid-frame: all outputs return to their reset values immediately. Counting restarts at 0 on the first clk with enable high after reset release.

## Timing
- Counters are registered. edge_count leaves 0 on the first clk after enable rises.
- Decision latency: sampled_bit and sample_valid become visible while edge_count == H+2:
  - P = 8: visible at 6
  - P = 16: visible at 10
  - P = 32: visible at 18
- In every legal case the decision lands before that bit's wrap.
- bit_count changes on the same clk that edge_count wraps to 0.
- The full frame occupies F × Prescale cycles of enable-high time.
- No combinational path from any input to any output.

## Configuration
- Macro: UART_RX_MAJORITY_SAMPLE_EN.
- Defined: 3-sample majority vote as described above; sample_glitch is live.
- Undefined: single capture at edge_count == H. sampled_bit takes that sample at the same H+1 decision point with identical latency. s0 and s2 are removed, and sample_glitch is tied to 0.

## Test plan
- Reset: assert rst mid-count with P = 16 and edge_count = 9 → all outputs return to their reset values immediately. Counting restarts at 0 after release with enable = 1.
- Counting, P = 8, PAR_EN = 0, enable held for 80 cycles:
  - edge_count steps 0..7 repeatedly
  - bit_count steps 0..9 and then wraps to 0
- Parity frame, P = 16, PAR_EN = 1, enable held for 176 cycles → bit_count reaches 10 and then returns to 0 at cycle 176.
- Majority vote, P = 16, samples 1,0,1 at edges 6/7/8 → at edge_count == 10: sampled_bit = 1, sample_valid = 1 for one cycle, sample_glitch = 1. With the macro undefined: sampled_bit = 1 (from edge 8) and glitch = 0.
- enable drops at edge_count = 5, P = 32 → next cycle edge_count = 0 and bit_count = 0. No sample_valid pulse is seen.
- data_sample_en low for a full bit, P = 8 → sample_valid stays 0 and sampled_bit keeps its previous value, while counters still advance.

Source files
------------

// File: rtl/uart_rx_edge_bit_sampler.sv
// uart_rx_edge_bit_sampler: edge/bit counters and once-per-bit RX sampler for the UART receiver.
// Define UART_RX_MAJORITY_SAMPLE_EN for a 3-sample majority vote; otherwise one mid-bit sample.
module uart_rx_edge_bit_sampler (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       data_sample_en,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    output logic [4:0] edge_count,
    output logic [3:0] bit_count,
    output logic       sampled_bit,
    output logic       sample_valid,
    output logic       sample_glitch
);
    logic [5:0] w_half, w_edge;
    logic [4:0] w_edge_nxt;
    logic [3:0] w_bit_nxt;
    logic       w_bit_end, w_frame_end, w_cap, w_decide, w_vote, w_glitch;

    assign w_half      = Prescale >> 1;
    assign w_edge      = {1'b0, edge_count};
    assign w_bit_end   = w_edge == Prescale - 6'd1;
    assign w_frame_end = bit_count == (PAR_EN ? 4'd10 : 4'd9);
    assign w_cap       = enable & data_sample_en;
    assign w_decide    = w_cap & (w_edge == w_half + 6'd1);

    always_comb begin
        w_edge_nxt = (!enable || w_bit_end) ? 5'd0 : edge_count + 5'd1;
        w_bit_nxt  = !enable ? 4'd0 : !w_bit_end ? bit_count : w_frame_end ? 4'd0 : bit_count + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_count <= 5'd0;
            bit_count  <= 4'd0;
        end else begin
            edge_count <= w_edge_nxt;
            bit_count  <= w_bit_nxt;
        end
    end

`ifdef UART_RX_MAJORITY_SAMPLE_EN
    logic r_s0, r_s1, r_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else if (w_cap) begin
            if (w_edge == w_half - 6'd2) r_s0 <= RX_IN;
            if (w_edge == w_half - 6'd1) r_s1 <= RX_IN;
            if (w_edge == w_half)        r_s2 <= RX_IN;
        end
    end

    assign w_vote   = (r_s0 & r_s1) | (r_s1 & r_s2) | (r_s0 & r_s2);
    assign w_glitch = (r_s0 ^ r_s1) | (r_s1 ^ r_s2);
`else
    logic r_s1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_s1 <= 1'b1;
        else if (w_cap && w_edge == w_half)
            r_s1 <= RX_IN;
    end

    assign w_vote   = r_s1;
    assign w_glitch = 1'b0;
`endif

    // Decision lands on the clk where edge_count == H+1, visible at H+2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sampled_bit   <= 1'b1;
            sample_valid  <= 1'b0;
            sample_glitch <= 1'b0;
        end else begin
            sample_valid <= w_decide;
            if (w_decide) begin
                sampled_bit   <= w_vote;
                sample_glitch <= w_glitch;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// tb_uart_rx_edge_bit_sampler: directed checks of counters, sampling and reset behaviour.
module tb_uart_rx_edge_bit_sampler;
    logic       clk = 1'b0;
    logic       rst, enable, dse, rx, par_en;
    logic [5:0] prescale;
    logic [4:0] edge_count;
    logic [3:0] bit_count;
    logic       sampled_bit, sample_valid, sample_glitch;
    int         total = 0;
    int         bad = 0;

`ifdef UART_RX_MAJORITY_SAMPLE_EN
    localparam logic EXP_GLITCH = 1'b1;
`else
    localparam logic EXP_GLITCH = 1'b0;
`endif

    uart_rx_edge_bit_sampler dut (
        .clk(clk), .rst(rst), .enable(enable), .data_sample_en(dse), .RX_IN(rx),
        .PAR_EN(par_en), .Prescale(prescale), .edge_count(edge_count), .bit_count(bit_count),
        .sampled_bit(sampled_bit), .sample_valid(sample_valid), .sample_glitch(sample_glitch)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [11:0] got;
        rst = 1'b0; enable = 1'b0; dse = 1'b0; rx = 1'b1; par_en = 1'b0; prescale = 6'd16;
        tick; tick;
        got = {edge_count, bit_count, sampled_bit, sample_valid, sample_glitch};
        total++;
        if (got !== 12'h004) begin bad++; $display("FAIL reset_init got=%h exp=004", got); end
        rst = 1'b1; enable = 1'b1; dse = 1'b1; rx = 1'b0;
        repeat (25) tick;
        got = {edge_count, bit_count, sampled_bit, sample_valid, sample_glitch};
        total++;
        if (got !== {5'd9, 4'd1, 3'b000}) begin bad++; $display("FAIL pre_reset_state got=%h exp=%h", got, {5'd9, 4'd1, 3'b000}); end
        #2 rst = 1'b0;
        #1 got = {edge_count, bit_count, sampled_bit, sample_valid, sample_glitch};
        total++;
        if (got !== 12'h004) begin bad++; $display("FAIL async_reset got=%h exp=004", got); end
        tick;
        rst = 1'b1;
        total++;
        if (edge_count !== 5'd0) begin bad++; $display("FAIL reset_release_edge got=%0d exp=0", edge_count); end
        tick;
        total++;
        if (edge_count !== 5'd1 || bit_count !== 4'd0) begin bad++; $display("FAIL restart_count got=%0d/%0d exp=1/0", edge_count, bit_count); end
    endtask

    task automatic test_count_p8;
        enable = 1'b0; dse = 1'b0; tick;
        prescale = 6'd8; par_en = 1'b0; enable = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            tick;
            total++;
            if (edge_count !== 5'(c % 8) || bit_count !== 4'((c / 8) % 10)) begin
                bad++;
                $display("FAIL count_p8 cyc=%0d got=%0d/%0d exp=%0d/%0d", c, edge_count, bit_count, c % 8, (c / 8) % 10);
            end
        end
    endtask

    task automatic test_parity_p16;
        enable = 1'b0; tick;
        prescale = 6'd16; par_en = 1'b1; enable = 1'b1;
        for (int c = 1; c <= 176; c++) begin
            tick;
            total++;
            if (edge_count !== 5'(c % 16) || bit_count !== 4'((c / 16) % 11)) begin
                bad++;
                $display("FAIL parity_p16 cyc=%0d got=%0d/%0d exp=%0d/%0d", c, edge_count, bit_count, c % 16, (c / 16) % 11);
            end
        end
        par_en = 1'b0;
    endtask

    task automatic test_majority;
        enable = 1'b0; tick;
        prescale = 6'd16; enable = 1'b1; dse = 1'b1;
        for (int c = 0; c < 32; c++) begin
            rx = (c >= 16) && ((c % 16) == 6 || (c % 16) == 8);
            tick;
            total++;
            if (((c + 1) % 16) == 10) begin
                if (sample_valid !== 1'b1 || sampled_bit !== (c >= 16) || sample_glitch !== ((c >= 16) && EXP_GLITCH)) begin
                    bad++;
                    $display("FAIL majority cyc=%0d got v=%b b=%b g=%b exp v=1 b=%b g=%b", c, sample_valid, sampled_bit, sample_glitch, c >= 16, (c >= 16) && EXP_GLITCH);
                end
            end else if (sample_valid !== 1'b0) begin
                bad++;
                $display("FAIL majority_valid cyc=%0d got=%b exp=0", c, sample_valid);
            end
        end
    endtask

    task automatic test_enable_drop;
        enable = 1'b0; tick;
        prescale = 6'd32; enable = 1'b1; dse = 1'b1; rx = 1'b1;
        repeat (37) tick;
        total++;
        if (edge_count !== 5'd5 || bit_count !== 4'd1) begin bad++; $display("FAIL pre_drop got=%0d/%0d exp=5/1", edge_count, bit_count); end
        enable = 1'b0;
        tick;
        total++;
        if (edge_count !== 5'd0 || bit_count !== 4'd0) begin bad++; $display("FAIL enable_drop got=%0d/%0d exp=0/0", edge_count, bit_count); end
        for (int c = 0; c < 20; c++) begin
            tick;
            total++;
            if (sample_valid !== 1'b0 || edge_count !== 5'd0) begin
                bad++;
                $display("FAIL disabled cyc=%0d got v=%b e=%0d exp v=0 e=0", c, sample_valid, edge_count);
            end
        end
    endtask

    task automatic test_dse_low_p8;
        logic exp_sb;
        logic exp_v;
        exp_sb = 1'b1;
        enable = 1'b0; tick;
        prescale = 6'd8; enable = 1'b1;
        for (int c = 0; c < 24; c++) begin
            dse = (c / 8) != 1;
            rx  = c >= 8;
            tick;
            exp_v = (((c + 1) % 8) == 6) && (((c + 1) / 8) != 1);
            if (exp_v) exp_sb = ((c + 1) / 8) >= 2;
            total++;
            if (sample_valid !== exp_v || sampled_bit !== exp_sb || edge_count !== 5'((c + 1) % 8) || bit_count !== 4'((c + 1) / 8)) begin
                bad++;
                $display("FAIL dse_low cyc=%0d got v=%b b=%b e=%0d bc=%0d exp v=%b b=%b e=%0d bc=%0d",
                         c, sample_valid, sampled_bit, edge_count, bit_count, exp_v, exp_sb, (c + 1) % 8, (c + 1) / 8);
            end
        end
    endtask

    initial begin
        test_reset;
        test_count_p8;
        test_parity_p16;
        test_majority;
        test_enable_drop;
        test_dse_low_p8;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
